// File: rtl/drr_pkg.sv
// Shared types and helpers for the deficit-round-robin pop scheduler.
// The QUANTUM_LATCH_EN macro is consumed by drr_pop_scheduler.sv.
package drr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        SERVE  = 2'd2
    } drr_state_e;

    // Upper bound on requesters that the index helper can scan.
    localparam int MAX_REQS = 32;

    // Returns the first non-empty index found scanning cyclically over n
    // entries. With skip_self the scan starts just after ptr, so ptr is
    // visited last and chosen only when it is the sole non-empty entry.
    // Returns ptr unchanged when every entry is empty.
    function automatic int next_nonempty(input int                  ptr,
                                         input logic [MAX_REQS-1:0] empty,
                                         input int                  n,
                                         input logic                skip_self);
        int start;
        int idx;
        int res;
        start = skip_self ? ((ptr + 1) % n) : ptr;
        res   = ptr;
        // Walk offsets from the far end down so the nearest hit wins.
        for (int k = MAX_REQS - 1; k >= 0; k--) begin
            if (k < n) begin
                idx = (start + k) % n;
                if (!empty[idx]) begin
                    res = idx;
                end
            end
        end
        return res;
    endfunction

    // Adds two unsigned values and clamps at 2^w-1 (w must be below 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int          w);
        logic [32:0] sum;
        logic [32:0] max_val;
        sum     = {1'b0, a} + {1'b0, b};
        max_val = (33'd1 << w) - 33'd1;
        return (sum > max_val) ? max_val[31:0] : sum[31:0];
    endfunction

endpackage

// File: rtl/drr_credit_counter.sv
// One requester's deficit counter: saturating quantum refill, fixed
// packet-cost debit and clear. Exactly one of clr/add_en/sub_en is
// expected per cycle; clr dominates, then add, then sub.
module drr_credit_counter
    import drr_pkg::*;
#(
    parameter int QWID  = 8,
    parameter int DCWID = QWID + 1,
    parameter int PSIZE = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             add_en,
    input  logic             sub_en,
    input  logic             clr,
    input  logic [QWID-1:0]  quantum,
    output logic             ge_psize,
    output logic [DCWID-1:0] deficit
);

    logic [DCWID-1:0] deficit_q;
    logic [DCWID-1:0] deficit_d;

    // Next deficit from the one active control.
    always_comb begin
        deficit_d = deficit_q;
        if (clr) begin
            deficit_d = '0;
        end else if (add_en) begin
            deficit_d = DCWID'(sat_add(32'(deficit_q), 32'(quantum), DCWID));
        end else if (sub_en) begin
            deficit_d = deficit_q - DCWID'(PSIZE);
        end
    end

    // Deficit register; reset discards any banked credit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            deficit_q <= '0;
        end else begin
            deficit_q <= deficit_d;
        end
    end

    assign ge_psize = (deficit_q >= DCWID'(PSIZE));
    assign deficit  = deficit_q;

endmodule

// File: rtl/drr_pop_scheduler.sv
// Deficit-round-robin pop sequencer for a bank of packet FIFOs.
// Optional feature macro: QUANTUM_LATCH_EN (quantums taken from a register
// loaded by quantum_ld instead of sampled live from input_quantums).
// Handshake: pop[i] is a one-cycle combinational command to FIFO i; it is
// only raised for a non-empty FIFO, with blk low and rst high, and the
// FIFO is expected to consume one packet on the same rising edge.
module drr_pop_scheduler
    import drr_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int QWID     = 8,
    parameter int PSIZE    = 8,
    parameter int DCWID    = QWID + 1,
    localparam int PTRW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      blk,
    input  logic [NUM_REQS-1:0]       empty,
    input  logic [NUM_REQS*QWID-1:0]  input_quantums,
    input  logic                      quantum_ld,
    output logic [NUM_REQS-1:0]       pop,
    output logic [PTRW-1:0]           sel,
    output logic                      busy,
    output logic [1:0]                dbg_state,
    output logic [NUM_REQS*DCWID-1:0] dbg_deficit
);

    drr_state_e            state_q, state_d;
    logic [PTRW-1:0]       ptr_q, ptr_d;
    logic [NUM_REQS-1:0]   add_en, sub_en, clr, ge;
    logic [NUM_REQS*QWID-1:0] quantum_src;
    logic                  any_ne;

`ifdef QUANTUM_LATCH_EN
    logic [NUM_REQS*QWID-1:0] q_reg_q;

    // Quantum shadow register; a load mid-turn only affects later refills.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg_q <= '0;
        end else if (quantum_ld) begin
            q_reg_q <= input_quantums;
        end
    end

    assign quantum_src = q_reg_q;
`else
    logic unused_quantum_ld;

    assign quantum_src       = input_quantums;
    assign unused_quantum_ld = quantum_ld;
`endif

    assign any_ne = ~(&empty);

    // FSM next state, pointer advance, counter controls and pop decode.
    // blk freezes everything, including the IDLE pick and advance decisions.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        add_en  = '0;
        sub_en  = '0;
        clr     = '0;
        pop     = '0;
        if (rst && !blk) begin
            case (state_q)
                IDLE: begin
                    if (any_ne) begin
                        ptr_d   = PTRW'(next_nonempty(int'(ptr_q), MAX_REQS'(empty),
                                                      NUM_REQS, 1'b0));
                        state_d = CREDIT;
                    end
                end
                CREDIT: begin
                    add_en[ptr_q] = 1'b1;
                    state_d       = SERVE;
                end
                SERVE: begin
                    if (!empty[ptr_q] && ge[ptr_q]) begin
                        pop[ptr_q]    = 1'b1;
                        sub_en[ptr_q] = 1'b1;
                    end else begin
                        // An empty FIFO forfeits its leftover credit; a
                        // starved one keeps it for the next turn.
                        if (empty[ptr_q]) begin
                            clr[ptr_q] = 1'b1;
                        end
                        if (any_ne) begin
                            ptr_d   = PTRW'(next_nonempty(int'(ptr_q), MAX_REQS'(empty),
                                                          NUM_REQS, 1'b1));
                            state_d = CREDIT;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and pointer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_cred
        drr_credit_counter #(
            .QWID  (QWID),
            .DCWID (DCWID),
            .PSIZE (PSIZE)
        ) u_cnt (
            .clk      (clk),
            .rst      (rst),
            .add_en   (add_en[i]),
            .sub_en   (sub_en[i]),
            .clr      (clr[i]),
            .quantum  (quantum_src[i*QWID +: QWID]),
            .ge_psize (ge[i]),
            .deficit  (dbg_deficit[i*DCWID +: DCWID])
        );
    end

    assign sel       = ptr_q;
    assign busy      = (state_q != IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_drr_pop_scheduler.sv
// Directed bench for drr_pop_scheduler with a packet-count FIFO model.
module tb_drr_pop_scheduler;

    localparam int NR = 4;
    localparam int QW = 8;
    localparam int DW = QW + 1;

    // ---------------- clock / DUT ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          blk = 1'b0;
    logic [NR-1:0] empty = '1;
    logic [NR*QW-1:0] input_quantums = '0;
    logic          quantum_ld = 1'b0;
    logic [NR-1:0] pop;
    logic [1:0]    sel;
    logic          busy;
    logic [1:0]    dbg_state;
    logic [NR*DW-1:0] dbg_deficit;

    always #5 clk = ~clk;

    drr_pop_scheduler #(.NUM_REQS(NR), .QWID(QW), .PSIZE(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .blk            (blk),
        .empty          (empty),
        .input_quantums (input_quantums),
        .quantum_ld     (quantum_ld),
        .pop            (pop),
        .sel            (sel),
        .busy           (busy),
        .dbg_state      (dbg_state),
        .dbg_deficit    (dbg_deficit)
    );

    // A pop into an empty FIFO, or more than one pop, is never legal.
    assert property (@(posedge clk) (pop & empty) == '0)
        else $error("FAIL pop_into_empty pop=%b empty=%b", pop, empty);
    assert property (@(posedge clk) $onehot0(pop))
        else $error("FAIL pop_onehot pop=%b", pop);

    // ---------------- stimulus plan and model ----------------
    logic          rst_plan = 1'b0;
    logic          blk_plan = 1'b0;
    logic          ld_plan  = 1'b0;
    logic [QW-1:0] q_plan [NR];
    int            pkt_cnt [NR];
    int            pop_cnt [NR];

    logic [NR-1:0]    s_pop;
    logic [1:0]       s_sel;
    logic             s_busy;
    logic [1:0]       s_state;
    logic [NR*DW-1:0] s_def;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] def_of(input int i);
        return 64'(s_def[i*DW +: DW]);
    endfunction

    // One clock: drive inputs on the falling edge, sample outputs, then let
    // the model consume whatever was popped on the rising edge.
    task automatic tick();
        @(negedge clk);
        rst        = rst_plan;
        blk        = blk_plan;
        quantum_ld = ld_plan;
        for (int i = 0; i < NR; i++) begin
            input_quantums[i*QW +: QW] = q_plan[i];
            empty[i] = (pkt_cnt[i] == 0);
        end
        #1;
        s_pop   = pop;
        s_sel   = sel;
        s_busy  = busy;
        s_state = dbg_state;
        s_def   = dbg_deficit;
        @(posedge clk);
        for (int i = 0; i < NR; i++) begin
            if (s_pop[i]) begin
                pkt_cnt[i]--;
                pop_cnt[i]++;
            end
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < NR; i++) pkt_cnt[i] = 0;
        blk_plan = 1'b0;
        rst_plan = 1'b0;
        tick();
        tick();
        rst_plan = 1'b1;
    endtask

    task automatic set_quantums(input int q0, input int q1, input int q2, input int q3);
        q_plan[0] = QW'(q0);
        q_plan[1] = QW'(q1);
        q_plan[2] = QW'(q2);
        q_plan[3] = QW'(q3);
        ld_plan = 1'b1;
        tick();
        ld_plan = 1'b0;
    endtask

    // ---------------- directed tests ----------------
    int exp_p2 [13] = '{0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0};
    int exp_bz [13] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};

    initial begin
        for (int i = 0; i < NR; i++) begin
            q_plan[i]  = '0;
            pkt_cnt[i] = 0;
            pop_cnt[i] = 0;
        end

        // Reset and idle hold.
        do_reset();
        for (int c = 0; c < 20; c++) begin
            tick();
            check($sformatf("idle_hold_%0d", c), 64'({s_pop, s_busy, s_sel}), 64'd0);
        end

        // Single requester 2, quantum 16, five packets.
        set_quantums(0, 0, 16, 0);
        pkt_cnt[2] = 5;
        for (int c = 0; c < 13; c++) begin
            tick();
            check($sformatf("single_pop_%0d", c), 64'(s_pop), exp_p2[c] ? 64'd4 : 64'd0);
            check($sformatf("single_busy_%0d", c), 64'(s_busy), 64'(exp_bz[c]));
            if (c == 1) check("single_sel", 64'(s_sel), 64'd2);
            if (c == 11) check("single_def_last", def_of(2), 64'd8);
            if (c == 12) check("single_def_drained", def_of(2), 64'd0);
        end
        check("single_pkts_left", 64'(pkt_cnt[2]), 64'd0);

        // Weighted share: one 18-cycle round yields 1/2/3/4 pops.
        do_reset();
        set_quantums(8, 16, 24, 32);
        for (int i = 0; i < NR; i++) pkt_cnt[i] = 1000;
        tick();
        for (int i = 0; i < NR; i++) pop_cnt[i] = 0;
        for (int c = 0; c < 198; c++) tick();
        begin
            int total;
            total = 0;
            for (int i = 0; i < NR; i++) begin
                int d;
                d = pop_cnt[i] - 11 * (i + 1);
                check($sformatf("share_req%0d_cnt%0d", i, pop_cnt[i]),
                      64'((d <= 1) && (d >= -1)), 64'd1);
                total += pop_cnt[i];
            end
            check("share_total", 64'(total), 64'd110);
        end
        for (int i = 0; i < NR; i++) pkt_cnt[i] = 0;
        for (int c = 0; c < 4; c++) tick();
        check("share_back_idle", 64'(s_busy), 64'd0);

        // Backpressure mid-SERVE on requester 1 with 16 credit.
        do_reset();
        set_quantums(0, 16, 0, 0);
        pkt_cnt[1] = 10;
        tick();
        tick();
        blk_plan = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("blk_pop_%0d", c), 64'(s_pop), 64'd0);
            check($sformatf("blk_def_%0d", c), def_of(1), 64'd16);
            check($sformatf("blk_state_%0d", c), 64'(s_state), 64'd2);
        end
        blk_plan = 1'b0;
        tick();
        check("blk_resume_pop", 64'(s_pop), 64'd2);
        pkt_cnt[1] = 0;
        for (int c = 0; c < 6; c++) tick();

        // Reset mid-turn on requester 3 holding 24 credit.
        do_reset();
        set_quantums(0, 0, 0, 24);
        pkt_cnt[3] = 10;
        tick();
        tick();
        rst_plan = 1'b0;
        tick();
        check("rst_mid_pop", 64'(s_pop), 64'd0);
        check("rst_mid_sel", 64'(s_sel), 64'd3);
        check("rst_mid_def", def_of(3), 64'd24);
        rst_plan   = 1'b1;
        pkt_cnt[3] = 0;
        tick();
        check("rst_after_state", 64'(s_state), 64'd0);
        check("rst_after_sel", 64'(s_sel), 64'd0);
        check("rst_after_def", 64'(s_def), 64'd0);

`ifdef QUANTUM_LATCH_EN
        // Latched quantums: live input changes need a load strobe.
        do_reset();
        set_quantums(8, 8, 8, 8);
        for (int i = 0; i < NR; i++) q_plan[i] = QW'(32);
        pkt_cnt[0] = 100;
        tick();
        pop_cnt[0] = 0;
        for (int c = 0; c < 9; c++) tick();
        check("latch_old_q_pops", 64'(pop_cnt[0]), 64'd3);
        pop_cnt[0] = 0;
        ld_plan = 1'b1;
        tick();
        ld_plan = 1'b0;
        tick();
        tick();
        check("latch_turn_in_flight", 64'(pop_cnt[0]), 64'd1);
        pop_cnt[0] = 0;
        for (int c = 0; c < 12; c++) tick();
        check("latch_new_q_pops", 64'(pop_cnt[0]), 64'd8);
        pkt_cnt[0] = 0;
        for (int c = 0; c < 8; c++) tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/drr_pop_scheduler.md
Name: drr_pop_scheduler

Overview:
Deficit-round-robin pop sequencer for a bank of NUM_REQS packet FIFOs feeding one shared output.
- Watches per-FIFO empty flags.
- Grants at most one pop per cycle, one-hot.
- Tracks per-requester deficit credit refilled from programmable quantums.
- Sits between the FIFO bank and the output mux; the scoreboard ties requester 0's pop to its magic-packet tracker.

Parameters:
NUM_REQS, 4, number of FIFOs/requesters
QWID, 8, quantum width per requester
PSIZE, 8, credit cost of one popped packet (constant)
DCWID, QWID+1, deficit counter width

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-low reset (0 = reset)
blk  input  1  downstream backpressure; 1 freezes scheduling
empty  input  NUM_REQS  per-FIFO empty flags
input_quantums  input  NUM_REQS*QWID  flat quantums, requester i at [(i+1)*QWID-1:i*QWID]
quantum_ld  input  1  quantum load strobe (used only with QUANTUM_LATCH_EN)
pop  output  NUM_REQS  one-hot pop grant, combinational
sel  output  $clog2(NUM_REQS)  index of requester currently in turn
busy  output  1  1 when state != IDLE

Behaviour:
- State and registers: state {IDLE, CREDIT, SERVE}, ptr, deficit[i] (DCWID bits each).
- Reset (rst==0 at posedge): state=IDLE, ptr=0, all deficit=0.
- While rst==0, pop=0 combinationally.
- Reset mid-turn abandons the turn and discards all credit.
- IDLE:
  - If &empty, stay.
  - Else ptr <= first non-empty index at or after ptr (cyclic); state <= CREDIT.
- CREDIT (one cycle, pop=0):
  - deficit[ptr] <= deficit[ptr] + quantum[ptr], saturating at 2^DCWID-1.
  - state <= SERVE.
- SERVE, pop[ptr] = ~empty[ptr] & ~blk & (deficit[ptr] >= PSIZE).
  - When pop fires: deficit[ptr] -= PSIZE; state stays SERVE.
  - If empty[ptr]: deficit[ptr] <= 0; advance.
  - Else if deficit[ptr] < PSIZE: keep deficit; advance.
- Advance:
  - ptr <= next non-empty index after ptr (cyclic, excluding ptr unless it is the only non-empty); state <= CREDIT.
  - If all empty, state <= IDLE.
- blk==1: pop=0 and all state, ptr and deficits hold. blk has priority over advance decisions.
- Latency: first pop two cycles after a requester leaves empty from IDLE (IDLE->CREDIT->SERVE).
- quantum[i]=0:
  - The requester gets CREDIT then advances immediately, unless leftover deficit >= PSIZE.
  - No livelock as long as any quantum >= PSIZE.
- A pop asserted into a FIFO that is empty is impossible by construction; the bench asserts this.
- sel = ptr at all times.

Optional Feature:
QUANTUM_LATCH_EN
- Defined:
  - Quantums come from internal register q_reg, cleared to 0 on reset.
  - q_reg loads input_quantums on any cycle with quantum_ld==1.
  - CREDIT uses q_reg.
  - A load during a turn affects only later CREDIT cycles.
- Undefined: quantum_ld is ignored; CREDIT samples input_quantums live.

Decomposition:
- Package drr_pkg:
  - state enum {IDLE, CREDIT, SERVE};
  - function next_nonempty(ptr, empty), returning cyclic next index;
  - saturating-add helper.
- Sub-module drr_credit_counter (one per requester):
  - holds deficit;
  - inputs add_en, sub_en, clr, quantum;
  - output ge_psize.
- The top holds the FSM, pointer and pop decode.

Test Plan:
- Reset and IDLE hold: reset, all empty, 20 cycles -> pop=0, busy=0, sel=0 throughout.
- Single requester, quantum 16:
  - empty[2] drops with 5 packets;
  - first pop two cycles after empty[2] falls;
  - then exactly 2 pops per turn, re-CREDIT between turns;
  - 5 packets drained in 3 turns;
  - deficit[2]=0 after drain.
- Weighted share:
  - quantums {8,16,24,32}, all FIFOs kept non-empty for 200 cycles;
  - pop counts in ratio 1:2:3:4 within ±1 packet per requester.
- blk mid-SERVE:
  - blk=1 for 5 cycles while requester 1 holds deficit 16;
  - pop=0 and deficit unchanged during blk;
  - pops resume on the first blk=0 cycle.
- Reset mid-turn:
  - assert rst=0 while SERVE on ptr=3 with deficit 24;
  - pop=0 in the same cycle;
  - next cycle state=IDLE, ptr=0, all deficits 0.
- QUANTUM_LATCH_EN:
  - q_reg loaded with 8s;
  - input_quantums changed to 32s without strobe -> one pop per turn;
  - after quantum_ld pulse -> four pops per turn.
